// File: rtl/occupancy_pkg.sv
// Shared types for the occupancy controller: FSM state encoding and sticky error codes.
package occupancy_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL,
    ST_HOLD,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

endpackage

// File: rtl/occupancy_ctrl_counter.sv
// occ_counter: saturating up/down occupancy counter with overflow/underflow strobes.
// Strobes and count_next are combinational so the controller can register its flags in step with count.
module occ_counter #(
  parameter int CAPACITY = 100,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hold,
  input  logic             increment,
  input  logic             decrement,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             ovf,
  output logic             unf
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic inc_only, dec_only;

  always_comb begin
    inc_only   = increment & ~decrement & ~hold & ~clear;
    dec_only   = decrement & ~increment & ~hold & ~clear;
    ovf        = inc_only & (count == CAP);
    unf        = dec_only & (count == '0);
    count_next = count;
    if (clear)
      count_next = '0;
    else if (inc_only && count < CAP)
      count_next = count + 1'b1;
    else if (dec_only && count != '0)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/occupancy_ctrl.sv
// Occupancy controller: FSM plus registered flags around occ_counter.
// Optional re-admit hysteresis after FULL is enabled by defining OCC_HOLDOFF_EN.
//
// state      | meaning
// ST_EMPTY   | count == 0, entry admitted
// ST_PARTIAL | 0 < count < CAPACITY, entry admitted
// ST_FULL    | count == CAPACITY, entry refused
// ST_HOLD    | left FULL, refused until count <= CAPACITY-HYST
// ST_ERROR   | overflow/underflow seen, count frozen until clear/rst
module occupancy_ctrl
  import occupancy_pkg::*;
#(
  parameter int CAPACITY = 100,
  parameter int CNT_W    = 8,
  parameter int HYST     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             increment,
  input  logic             decrement,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             admit,
  output logic             err,
  output logic [1:0]       err_code
);

`ifdef OCC_HOLDOFF_EN
  localparam bit HOLDOFF = 1'b1;
`else
  localparam bit HOLDOFF = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] READMIT = CNT_W'(CAPACITY - HYST);

  state_t           state, state_next;
  logic [CNT_W-1:0] count_next;
  logic             ovf, unf;
  logic             err_next;
  logic [1:0]       code_next;

  occ_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .hold       (state == ST_ERROR),
    .increment  (increment),
    .decrement  (decrement),
    .count      (count),
    .count_next (count_next),
    .ovf        (ovf),
    .unf        (unf)
  );

  function automatic state_t classify(input logic [CNT_W-1:0] c);
    if (c == '0)       return ST_EMPTY;
    else if (c == CAP) return ST_FULL;
    else               return ST_PARTIAL;
  endfunction

  always_comb begin
    state_next = state;
    err_next   = err;
    code_next  = err_code;
    if (clear) begin
      state_next = ST_EMPTY;
      err_next   = 1'b0;
      code_next  = ERR_NONE;
    end else if (state != ST_ERROR) begin
      if (ovf) begin
        state_next = ST_ERROR;
        err_next   = 1'b1;
        code_next  = ERR_OVF;
      end else if (unf) begin
        state_next = ST_ERROR;
        err_next   = 1'b1;
        code_next  = ERR_UNF;
      end else if (state == ST_HOLD) begin
        if (count_next == CAP)
          state_next = ST_FULL;
        else if (count_next <= READMIT)
          state_next = classify(count_next);
      end else if (HOLDOFF && state == ST_FULL && count_next != CAP) begin
        state_next = ST_HOLD;
      end else begin
        state_next = classify(count_next);
      end
    end
  end

  // Flags derive from next-cycle values so they stay aligned with the registered count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      empty    <= 1'b1;
      full     <= 1'b0;
      admit    <= 1'b1;
    end else begin
      state    <= state_next;
      err      <= err_next;
      err_code <= code_next;
      empty    <= (count_next == '0);
      full     <= (count_next == CAP);
      admit    <= (state_next == ST_EMPTY) || (state_next == ST_PARTIAL);
    end
  end

endmodule

// File: tb/tb_occupancy_ctrl.sv
// Directed plus randomized bench for occupancy_ctrl (CAPACITY=4, HYST=2) against an abstract occupancy model.
module tb_occupancy_ctrl;

  localparam int CAP   = 4;
  localparam int HYST  = 2;
  localparam int CNT_W = 8;
`ifdef OCC_HOLDOFF_EN
  localparam bit HOLDOFF = 1'b1;
`else
  localparam bit HOLDOFF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, increment, decrement, clear;
  logic [CNT_W-1:0] count;
  logic             empty, full, admit, err;
  logic [1:0]       err_code;

  int checks = 0;
  int errors = 0;

  int m_cnt  = 0;
  int m_err  = 0;
  int m_code = 0;
  int m_hold = 0;

  always #5 clk = ~clk;

  occupancy_ctrl #(.CAPACITY(CAP), .CNT_W(CNT_W), .HYST(HYST)) dut (
    .clk       (clk),
    .rst       (rst),
    .increment (increment),
    .decrement (decrement),
    .clear     (clear),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .admit     (admit),
    .err       (err),
    .err_code  (err_code)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Occupancy rules: people in the room, sticky fault, and re-admit hold-off after being full.
  task automatic model_step(input bit i, input bit d, input bit c, input bit r);
    if (r || c) begin
      m_cnt = 0; m_err = 0; m_code = 0; m_hold = 0;
    end else if (m_err != 0) begin
    end else if (i && !d) begin
      if (m_cnt == CAP) begin
        m_err = 1; m_code = 1;
      end else begin
        m_cnt++;
        if (m_cnt == CAP) m_hold = 0;
      end
    end else if (d && !i) begin
      if (m_cnt == 0) begin
        m_err = 1; m_code = 2;
      end else begin
        if (m_hold != 0 && m_cnt - 1 <= CAP - HYST) m_hold = 0;
        if (HOLDOFF && m_cnt == CAP) m_hold = 1;
        m_cnt--;
      end
    end
  endtask

  task automatic cycle(input bit i, input bit d, input bit c, input bit r, input string tag);
    increment = i; decrement = d; clear = c; rst = r;
    @(posedge clk);
    model_step(i, d, c, r);
    @(negedge clk);
    check({tag, ".count"},    count,        8'(m_cnt));
    check({tag, ".empty"},    8'(empty),    8'(m_cnt == 0));
    check({tag, ".full"},     8'(full),     8'(m_cnt == CAP));
    check({tag, ".admit"},    8'(admit),    8'(m_err == 0 && m_cnt != CAP && m_hold == 0));
    check({tag, ".err"},      8'(err),      8'(m_err));
    check({tag, ".err_code"}, 8'(err_code), 8'(m_code));
  endtask

  initial begin
    bit i, d, c, r;
    increment = 0; decrement = 0; clear = 0; rst = 1;

    cycle(0, 0, 0, 1, "reset");
    check("reset.count_const", count, 8'd0);
    check("reset.admit_const", 8'(admit), 8'd1);

    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 0, "fill");
    check("fill.full_const",  8'(full),  8'd1);
    check("fill.admit_const", 8'(admit), 8'd0);
    cycle(1, 0, 0, 0, "overflow");
    check("overflow.code_const", 8'(err_code), 8'd1);
    cycle(0, 1, 0, 0, "error_frozen");
    check("error_frozen.count_const", count, 8'd4);

    cycle(0, 0, 1, 0, "clear");
    cycle(0, 1, 0, 0, "underflow");
    check("underflow.code_const", 8'(err_code), 8'd2);
    cycle(1, 0, 1, 0, "clear_wins");
    check("clear_wins.count_const", count, 8'd0);

    cycle(1, 0, 0, 0, "inc1");
    cycle(1, 0, 0, 0, "inc2");
    cycle(1, 1, 0, 0, "both");
    check("both.count_const", count, 8'd2);

    cycle(1, 0, 0, 0, "refill3");
    cycle(1, 0, 0, 0, "refill4");
    cycle(0, 1, 0, 0, "dec_from_full");
    check("dec_from_full.count_const", count, 8'd3);
    check("dec_from_full.admit_const", 8'(admit), HOLDOFF ? 8'd0 : 8'd1);
    cycle(1, 0, 0, 0, "hold_refull");
    cycle(0, 1, 0, 0, "hold_again");
    cycle(0, 1, 0, 0, "readmit");
    check("readmit.admit_const", 8'(admit), 8'd1);

    cycle(1, 0, 0, 1, "rst_mid_event");
    check("rst_mid_event.count_const", count, 8'd0);
    cycle(1, 0, 0, 0, "first_after_rst");
    check("first_after_rst.count_const", count, 8'd1);

    for (int k = 0; k < 800; k++) begin
      r = ($urandom % 64) == 0;
      c = ($urandom % 20) == 0;
      i = ($urandom % 100) < 50;
      d = ($urandom % 100) < 40;
      cycle(i, d, c, r, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/occupancy_ctrl.md
OCCUPANCY_CTRL -- requirements
Module: occupancy_ctrl

Interface
REQ-001 Parameter CAPACITY, default 100: maximum legal occupancy count.
REQ-002 Parameter CNT_W, default 8: width of count; CAPACITY < 2**CNT_W SHALL hold.
REQ-003 Parameter HYST, default 4: re-admit hysteresis; 0 < HYST < CAPACITY SHALL hold.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 increment  input  1  one-cycle pulse: one entry detected by the direction FSM.
REQ-007 decrement  input  1  one-cycle pulse: one exit detected by the direction FSM.
REQ-008 clear  input  1  synchronous soft clear of count and error.
REQ-009 count  output  CNT_W  current occupancy, registered.
REQ-010 empty / full  output  1 each  registered flags: count==0, count==CAPACITY.
REQ-011 admit  output  1  registered entry-permit to gate/door logic.
REQ-012 err  output  1  sticky error flag.
REQ-013 err_code  output  2  2'b01 overflow, 2'b10 underflow, 2'b00 none; sticky with err.

Function
REQ-014 All outputs SHALL be registered; response to an input event SHALL appear exactly 1 cycle after the sampling edge.
REQ-015 States: EMPTY, PARTIAL, FULL, HOLD, ERROR; every combinational block SHALL assign all outputs/next-state on every path (no inferred latches).
REQ-016 increment alone, count<CAPACITY: count+1. decrement alone, count>0: count-1.
REQ-017 increment and decrement same cycle: count unchanged, no error, state unchanged.
REQ-018 increment alone at count==CAPACITY: count held, err=1, err_code=01, state->ERROR.
REQ-019 decrement alone at count==0: count held at 0, err=1, err_code=10, state->ERROR.
REQ-020 ERROR: count frozen, increment/decrement ignored, admit=0; exit only via clear or rst.
REQ-021 clear (any state) SHALL override increment/decrement: count=0, err=0, err_code=00, state->EMPTY.
REQ-022 Next state from new count outside ERROR/HOLD: 0->EMPTY, CAPACITY->FULL, otherwise PARTIAL.
REQ-023 admit=1 in EMPTY and PARTIAL; admit=0 in FULL, HOLD, ERROR.
REQ-024 Counter arithmetic SHALL never wrap; count stays within 0..CAPACITY.

Reset
REQ-025 rst SHALL win over clear and events: count=0, empty=1, full=0, admit=1, err=0, err_code=00, state=EMPTY.
REQ-026 rst asserted mid-event SHALL discard the event; first event after deassertion SHALL be counted normally.

Configuration
REQ-027 Macro OCC_HOLDOFF_EN defined: a decrement from FULL SHALL enter HOLD; HOLD returns to PARTIAL only when count <= CAPACITY-HYST, re-enters FULL on count==CAPACITY, admit=0 throughout HOLD.
REQ-028 Macro OCC_HOLDOFF_EN undefined: HOLD SHALL be unreachable; FULL->PARTIAL on first decrement; HYST unused.

Structure
REQ-029 Package occupancy_pkg SHALL hold the state enumeration and err_code constants (ERR_NONE, ERR_OVF, ERR_UNF).
REQ-030 Sub-module occ_counter SHALL implement the saturating up/down counter with overflow/underflow strobes; occupancy_ctrl holds the FSM and output registers.

Verification
REQ-031 rst 1 cycle -> count=0, empty=1, admit=1, err=0 next cycle.
REQ-032 CAPACITY=4: 4 increment pulses -> count=4, full=1, admit=0; 5th increment -> count=4, err=1, err_code=01.
REQ-033 Count 0, one decrement -> err=1, err_code=10, count=0; then clear with increment same cycle -> count=0, err=0, state EMPTY.
REQ-034 Count 2, increment and decrement same cycle -> count=2, err=0, admit=1.
REQ-035 CAPACITY=4, HYST=2, OCC_HOLDOFF_EN: fill to 4, decrement -> count=3, admit=0; decrement -> count=2, admit=1. Without macro: first decrement -> count=3, admit=1.
REQ-036 Drive increment/decrement from fsm_example pulses with rst asserted during INCOCC -> count=0 after reset; lint shows zero latches.
